// File: rtl/nw_row_scorer.sv
// nw_row_scorer: runtime-loaded global/local alignment scorer.
// One DP cell per cycle, row-major, against a single previous-row buffer.
module nw_row_scorer #(
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int SYM_W   = 2,
  parameter int SCORE_W = 16,
  localparam int MX     = (N > M) ? N : M,
  localparam int AW     = (MX > 1) ? $clog2(MX) : 1,
  localparam int AI     = $clog2(N + 1),
  localparam int AJ     = $clog2(M + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic                      load_sel,
  input  logic [AW-1:0]             load_addr,
  input  logic [SYM_W-1:0]          load_data,
  input  logic                      start,
  input  logic                      mode,
  input  logic signed [SCORE_W-1:0] match_score,
  input  logic signed [SCORE_W-1:0] mismatch_penalty,
  input  logic signed [SCORE_W-1:0] gap_penalty,
  output logic                      busy,
  output logic                      finish,
  output logic signed [SCORE_W-1:0] solution,
  output logic [AI-1:0]             best_i,
  output logic [AJ-1:0]             best_j
);

  localparam int SW    = SCORE_W;
  localparam int KW    = AW + 1;
  localparam int PW    = SW + KW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0] LAST_R = AW'(N - 1);
  localparam logic [AW-1:0] LAST_C = AW'(M - 1);
  localparam logic [AW:0]   N_LIM  = (AW + 1)'(N);
  localparam logic [AW:0]   M_LIM  = (AW + 1)'(M);

  localparam logic signed [SW-1:0] SMAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {1'b1, {(SW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    COMPUTE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYM_W-1:0] a_mem [DEPTH];
  logic [SYM_W-1:0] b_mem [DEPTH];
  logic signed [SW-1:0] rowbuf [DEPTH];

  logic                 mode_q;
  logic signed [SW-1:0] match_q, mis_q, gap_q;
  logic [AW-1:0]        ri, cj;
  logic signed [SW-1:0] diag_q, left_q, best_q;
  logic [AI-1:0]        bi_q;
  logic [AJ-1:0]        bj_q;

  logic signed [SW-1:0] up, diag, left, col_cur, col_prev;
  logic signed [SW-1:0] sub, hd, hu, hl, h;
  logic                 last_cell;

  function automatic logic signed [SW-1:0] add_sat(
    input logic signed [SW-1:0] x,
    input logic signed [SW-1:0] y
  );
    logic [SW:0] s;
    s = {x[SW-1], x} + {y[SW-1], y};
    if (s[SW] != s[SW-1]) return s[SW] ? SMIN : SMAX;
    return s[SW-1:0];
  endfunction

  // k*g with k >= 0; wide product clamped to the score range
  function automatic logic signed [SW-1:0] mul_sat(
    input logic [KW-1:0]        k,
    input logic signed [SW-1:0] g
  );
    logic signed [PW-1:0] kx, gx, p;
    kx = PW'($signed({1'b0, k}));
    gx = PW'(g);
    p  = kx * gx;
    if (p[PW-1:SW-1] == '0 || p[PW-1:SW-1] == '1) return p[SW-1:0];
    return p[PW-1] ? SMIN : SMAX;
  endfunction

  always_ff @(posedge clk) begin
    if (state_q == IDLE && load_valid) begin
      if (!load_sel && {1'b0, load_addr} < N_LIM) a_mem[load_addr] <= load_data;
      if (load_sel && {1'b0, load_addr} < M_LIM) b_mem[load_addr] <= load_data;
    end
  end

  assign last_cell = (ri == LAST_R) && (cj == LAST_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = COMPUTE;
      COMPUTE: if (last_cell) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_cur  = '0;
    col_prev = '0;
    if (!mode_q) begin
      col_cur  = mul_sat(KW'(ri) + KW'(1), gap_q);
      col_prev = mul_sat(KW'(ri), gap_q);
    end
    up   = rowbuf[cj];
    diag = (cj == '0) ? col_prev : diag_q;
    left = (cj == '0) ? col_cur : left_q;
    sub  = (a_mem[ri] == b_mem[cj]) ? match_q : mis_q;
    hd   = add_sat(diag, sub);
    hu   = add_sat(up, gap_q);
    hl   = add_sat(left, gap_q);
    h    = hd;
    if (hu > h) h = hu;
    if (hl > h) h = hl;
    if (mode_q && h[SW-1]) h = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      finish   <= 1'b0;
      solution <= '0;
      best_i   <= '0;
      best_j   <= '0;
      mode_q   <= 1'b0;
      match_q  <= '0;
      mis_q    <= '0;
      gap_q    <= '0;
      ri       <= '0;
      cj       <= '0;
      diag_q   <= '0;
      left_q   <= '0;
      best_q   <= '0;
      bi_q     <= '0;
      bj_q     <= '0;
      for (int c = 0; c < DEPTH; c++) rowbuf[c] <= '0;
    end else begin
      finish <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            mode_q  <= mode;
            match_q <= match_score;
            mis_q   <= mismatch_penalty;
            gap_q   <= gap_penalty;
          end
        end
        INIT: begin
          for (int c = 0; c < DEPTH; c++)
            rowbuf[c] <= mode_q ? '0 : mul_sat(KW'(c + 1), gap_q);
          ri     <= '0;
          cj     <= '0;
          best_q <= '0;
          bi_q   <= '0;
          bj_q   <= '0;
        end
        COMPUTE: begin
          rowbuf[cj] <= h;
          diag_q     <= up;
          left_q     <= h;
          // strict compare keeps the first maximum in row-major order
          if (mode_q && h > best_q) begin
            best_q <= h;
            bi_q   <= AI'(ri) + AI'(1);
            bj_q   <= AJ'(cj) + AJ'(1);
          end
          if (cj == LAST_C) begin
            cj <= '0;
            ri <= ri + 1'b1;
          end else begin
            cj <= cj + 1'b1;
          end
        end
        DONE: begin
          finish   <= 1'b1;
          busy     <= 1'b0;
          solution <= mode_q ? best_q : left_q;
          best_i   <= mode_q ? bi_q : '0;
          best_j   <= mode_q ? bj_q : '0;
        end
        default: ;
      endcase
    end
  end

endmodule
